// File: rtl/receptor_serial_pkg.sv
// Shared constants for the serial ADC receiver.
// Holds the FSM state encodings, the default word width and the default SCLK half-period.
package receptor_serial_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } estado_t;

    // Default received word width (ANCHO).
    localparam int DEF_ANCHO = 16;

    // Default SCLK half-period in clk cycles (DIV).
    localparam int DEF_DIV = 4;

    // Number of leading bits that must be zero when the zero check is built in.
    localparam int CEROS_BITS = 4;

endpackage

// File: rtl/receptor_serial_if.sv
// Bus between a host/ADC side and the serial receiver.
// The optional error flag exists only when RECEPTOR_CHECK_CEROS_EN is defined.
interface receptor_serial_if
    import receptor_serial_pkg::*;
#(
    parameter int ANCHO = DEF_ANCHO
);

    logic             iniciar;
    logic             dato_serial;
    logic             sclk;
    logic             cs_n;
    logic [ANCHO-1:0] datos;
    logic             listo;
    logic             ocupado;

`ifdef RECEPTOR_CHECK_CEROS_EN
    logic             error;

    modport slave (
        input  iniciar, dato_serial,
        output sclk, cs_n, datos, listo, ocupado, error
    );

    modport master (
        output iniciar, dato_serial,
        input  sclk, cs_n, datos, listo, ocupado, error
    );
`else
    modport slave (
        input  iniciar, dato_serial,
        output sclk, cs_n, datos, listo, ocupado
    );

    modport master (
        output iniciar, dato_serial,
        input  sclk, cs_n, datos, listo, ocupado
    );
`endif

endinterface

// File: rtl/receptor_serial_divisor_sclk.sv
// SCLK phase timer: emits a one-cycle tick every DIV cycles while enabled,
// and restarts from zero whenever it is disabled.
module divisor_sclk
    import receptor_serial_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    logic [7:0] cuenta_q;
    logic [7:0] cuenta_d;

    assign tick = en && (cuenta_q == 8'(DIV - 1));

    // Count up while enabled, wrap on the tick, hold at zero while disabled.
    always_comb begin
        cuenta_d = '0;
        if (en && !tick) begin
            cuenta_d = cuenta_q + 8'd1;
        end
    end

    // Phase counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/receptor_serial.sv
// Serial ADC receiver: drives cs_n/sclk, shifts in ANCHO bits MSB first on
// sclk rising edges and presents the complete word on datos with a listo pulse.
// Optional feature macro: RECEPTOR_CHECK_CEROS_EN (flags nonzero leading bits).
module receptor_serial
    import receptor_serial_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int ANCHO = DEF_ANCHO
) (
    input logic              clk,
    input logic              reset,
    receptor_serial_if.slave bus
);

    localparam int CW = $clog2(ANCHO);

    estado_t          state_q, state_d;
    logic [CW-1:0]    contador_q, contador_d;
    logic             fin_q, fin_d;
    logic [ANCHO-1:0] shift_q, shift_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic [ANCHO-1:0] datos_q, datos_d;
    logic             listo_q, listo_d;
`ifdef RECEPTOR_CHECK_CEROS_EN
    logic             error_q, error_d;
`endif

    logic div_en;
    logic tick;

    assign div_en = (state_q == CS_SETUP) || (state_q == SHIFT);

    divisor_sclk #(
        .DIV (DIV)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .en    (div_en),
        .tick  (tick)
    );

    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.datos   = datos_q;
    assign bus.listo   = listo_q;
    assign bus.ocupado = (state_q != IDLE);
`ifdef RECEPTOR_CHECK_CEROS_EN
    assign bus.error   = error_q;
`endif

    // Next-state logic; outputs are computed for the state being entered so the registers line up with it.
    always_comb begin
        state_d    = state_q;
        contador_d = contador_q;
        fin_d      = fin_q;
        shift_d    = shift_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        datos_d    = datos_q;
        listo_d    = 1'b0;
`ifdef RECEPTOR_CHECK_CEROS_EN
        error_d    = error_q;
`endif
        case (state_q)
            IDLE: begin
                contador_d = '0;
                fin_d      = 1'b0;
                cs_n_d     = 1'b1;
                sclk_d     = 1'b1;
                if (bus.iniciar) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        // Rising sclk edge: capture the bit; the last bit sets fin instead of wrapping contador.
                        sclk_d = 1'b1;
                        shift_d[ANCHO - 1 - int'(contador_q)] = bus.dato_serial;
                        if (contador_q == CW'(ANCHO - 1)) begin
                            fin_d = 1'b1;
                        end else begin
                            contador_d = contador_q + 1'b1;
                        end
                    end else if (fin_q) begin
                        // High phase of the last bit is over: publish the word.
                        state_d = DONE;
                        sclk_d  = 1'b1;
                        cs_n_d  = 1'b1;
                        datos_d = shift_q;
                        listo_d = 1'b1;
`ifdef RECEPTOR_CHECK_CEROS_EN
                        error_d = |shift_q[ANCHO-1 -: CEROS_BITS];
`endif
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                contador_d = '0;
                fin_d      = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            contador_q <= '0;
            fin_q      <= 1'b0;
            shift_q    <= '0;
            sclk_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            datos_q    <= '0;
            listo_q    <= 1'b0;
`ifdef RECEPTOR_CHECK_CEROS_EN
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            contador_q <= contador_d;
            fin_q      <= fin_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            datos_q    <= datos_d;
            listo_q    <= listo_d;
`ifdef RECEPTOR_CHECK_CEROS_EN
            error_q    <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_receptor_serial.sv
// Directed bench for receptor_serial: one instance with DIV=4, one with DIV=1,
// each fed by a small ADC model that shifts data out MSB first on sclk falling edges.
module tb_receptor_serial;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    receptor_serial_if #(.ANCHO(16)) bus4 ();
    receptor_serial_if #(.ANCHO(16)) bus1 ();

    receptor_serial #(.DIV(4), .ANCHO(16)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    receptor_serial #(.DIV(1), .ANCHO(16)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // ADC model for the DIV=4 instance: one fixed word per frame.
    logic [15:0] adc4_word;
    int          k4;

    always @(negedge bus4.cs_n) k4 = 0;

    always @(negedge bus4.sclk) begin
        if (bus4.cs_n === 1'b0 && k4 < 16) begin
            bus4.dato_serial = adc4_word[15 - k4];
            k4++;
        end
    end

    // ADC model for the DIV=1 instance: takes the next word from a list at each frame start.
    logic [15:0] words1 [0:1];
    logic [15:0] cur1;
    int          f1;
    int          k1;

    always @(negedge bus1.cs_n) begin
        cur1 = (f1 < 2) ? words1[f1] : 16'h0000;
        f1++;
        k1 = 0;
    end

    always @(negedge bus1.sclk) begin
        if (bus1.cs_n === 1'b0 && k1 < 16) begin
            bus1.dato_serial = cur1[15 - k1];
            k1++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one DIV=4 frame from a negedge (cycle t0) and watches n cycles.
    // extra_ini pulses iniciar at t0+10 and t0+70; reset_at>0 asserts reset in that cycle.
    task automatic applyStimulus(
        input  logic [15:0] w,
        input  int          n,
        input  bit          extra_ini,
        input  int          reset_at,
        output int          listo_at,
        output int          listo_cnt,
        output int          low_cnt,
        output logic [15:0] dat,
        output logic        ocup1,
        output logic [18:0] snap
    );
        listo_at  = 0;
        listo_cnt = 0;
        low_cnt   = 0;
        dat       = 16'h0;
        ocup1     = 1'b0;
        snap      = '0;
        adc4_word = w;
        bus4.iniciar = 1'b1;
        for (int m = 1; m <= n; m++) begin
            @(negedge clk);
            if (bus4.cs_n === 1'b0) low_cnt++;
            if (bus4.listo === 1'b1) begin
                listo_cnt++;
                listo_at = m;
                dat = bus4.datos;
            end
            if (m == 1) ocup1 = bus4.ocupado;
            if (reset_at > 0 && m == reset_at + 1) begin
                snap  = {bus4.cs_n, bus4.sclk, bus4.ocupado, bus4.datos};
                reset = 1'b0;
            end
            bus4.iniciar = extra_ini && (m == 10 || m == 70);
            if (reset_at > 0 && m == reset_at) reset = 1'b1;
        end
    endtask

    int          la, lc, low;
    logic [15:0] dat;
    logic        ocup1;
    logic [18:0] snap;

    int          cnt1, la1a, la1b;
    logic [15:0] d1a, d1b, held1;
    logic        ocup35, ocup36;

    initial begin
        bus4.iniciar     = 1'b0;
        bus4.dato_serial = 1'b0;
        bus1.iniciar     = 1'b0;
        bus1.dato_serial = 1'b0;
        adc4_word        = 16'h0;
        words1[0]        = 16'h1234;
        words1[1]        = 16'h0FFF;
        cur1             = 16'h0;
        f1               = 0;
        k1               = 0;
        k4               = 0;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n",    bus4.cs_n,    1);
        checkOutput("rst_sclk",    bus4.sclk,    1);
        checkOutput("rst_datos",   bus4.datos,   0);
        checkOutput("rst_listo",   bus4.listo,   0);
        checkOutput("rst_ocupado", bus4.ocupado, 0);
        checkOutput("rst1_datos",  bus1.datos,   0);
`ifdef RECEPTOR_CHECK_CEROS_EN
        checkOutput("rst_error",   bus4.error,   0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Nominal frame 16'hA5C3 at DIV=4.
        applyStimulus(16'hA5C3, 140, 1'b0, 0, la, lc, low, dat, ocup1, snap);
        checkOutput("a5c3_listo_at",  la,  133);
        checkOutput("a5c3_listo_cnt", lc,  1);
        checkOutput("a5c3_cs_low",    low, 132);
        checkOutput("a5c3_datos",     dat, 16'hA5C3);
        checkOutput("a5c3_ocup_t1",   ocup1, 1);
        checkOutput("a5c3_ocup_end",  bus4.ocupado, 0);
        checkOutput("a5c3_hold",      bus4.datos, 16'hA5C3);
        checkOutput("a5c3_idle_sclk", bus4.sclk, 1);

        // Bit ordering at both ends of the word.
        applyStimulus(16'h0001, 140, 1'b0, 0, la, lc, low, dat, ocup1, snap);
        checkOutput("lsb_datos", dat, 16'h0001);
        applyStimulus(16'h8000, 140, 1'b0, 0, la, lc, low, dat, ocup1, snap);
        checkOutput("msb_datos", dat, 16'h8000);
        checkOutput("msb_hold",  bus4.datos, 16'h8000);

        // iniciar pulses during a frame must be ignored and not queued.
        applyStimulus(16'h3C5A, 300, 1'b1, 0, la, lc, low, dat, ocup1, snap);
        checkOutput("ign_listo_cnt", lc,  1);
        checkOutput("ign_listo_at",  la,  133);
        checkOutput("ign_cs_low",    low, 132);
        checkOutput("ign_datos",     dat, 16'h3C5A);

        // Reset in the middle of a frame aborts it.
        applyStimulus(16'hFFFF, 200, 1'b0, 60, la, lc, low, dat, ocup1, snap);
        checkOutput("mid_rst_snap",  snap, {1'b1, 1'b1, 1'b0, 16'h0000});
        checkOutput("mid_rst_listo", lc,   0);
        checkOutput("mid_rst_datos", bus4.datos, 0);

`ifdef RECEPTOR_CHECK_CEROS_EN
        // Leading-zero check on the first four received bits.
        applyStimulus(16'hF000, 140, 1'b0, 0, la, lc, low, dat, ocup1, snap);
        checkOutput("err_set",   bus4.error, 1);
        applyStimulus(16'h0ABC, 140, 1'b0, 0, la, lc, low, dat, ocup1, snap);
        checkOutput("err_clear", bus4.error, 0);
        checkOutput("err_datos", dat, 16'h0ABC);
`endif

        // Back-to-back frames with iniciar held high at DIV=1.
        cnt1 = 0; la1a = 0; la1b = 0;
        d1a = 16'h0; d1b = 16'h0; held1 = 16'h0;
        ocup35 = 1'b1; ocup36 = 1'b0;
        bus1.iniciar = 1'b1;
        for (int m = 1; m <= 80; m++) begin
            @(negedge clk);
            if (bus1.listo === 1'b1) begin
                cnt1++;
                if (cnt1 == 1) begin
                    la1a = m;
                    d1a  = bus1.datos;
                end else if (cnt1 == 2) begin
                    la1b = m;
                    d1b  = bus1.datos;
                end
            end
            if (m == 35) ocup35 = bus1.ocupado;
            if (m == 36) ocup36 = bus1.ocupado;
            if (m == 50) held1  = bus1.datos;
            if (m == 69) bus1.iniciar = 1'b0;
        end
        checkOutput("b2b_listo_a", la1a, 34);
        checkOutput("b2b_listo_b", la1b, 69);
        checkOutput("b2b_datos_a", d1a,  16'h1234);
        checkOutput("b2b_datos_b", d1b,  16'h0FFF);
        checkOutput("b2b_count",   cnt1, 2);
        checkOutput("b2b_hold",    held1, 16'h1234);
        checkOutput("b2b_gap_idle", ocup35, 0);
        checkOutput("b2b_restart",  ocup36, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
